// File: rtl/mac_accum_pkg.sv
// mac_accum_pkg: shared types and register-map constants for the MAC accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Ports: none.
package mac_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ACCUM = 2'd2
  } state_t;

  // Register offsets (RS)
  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_B0   = 2'd1;
  localparam logic [1:0] REG_B1   = 2'd2;
  localparam logic [1:0] REG_B2   = 2'd3;

  // CTRL write bits
  localparam int CTRL_GO  = 0;
  localparam int CTRL_SUB = 1;
  localparam int CTRL_CLR = 2;

  // STATUS read bits
  localparam int ST_BUSY = 0;
  localparam int ST_OVF  = 1;
  localparam int ST_NZ   = 2;
  localparam int ST_LOST = 3;

endpackage

// File: rtl/mac_accum_if.sv
// mac_accum_if: 6502-side bus controls (chip enable, read/write, register select).
// Latency: n/a (wires only).
// Backpressure: none; the 6502 bus has no stall.
// Signals: CE chip enable, RWB 1=read 0=write, RS register select.
interface mac_accum_if;
  logic       CE;
  logic       RWB;
  logic [1:0] RS;

  modport master (output CE, RWB, RS);
  modport slave  (input  CE, RWB, RS);
endinterface

// File: rtl/mac_accum_bus_strobe.sv
// bus_strobe: turns level-held CE/RWB accesses into single-cycle write/read events.
// Latency: event is combinational on the first cycle of an access.
// Backpressure: none; an access held for many cycles fires once.
// Ports: clk, rst, i_ce, i_rwb -> o_wr_evt, o_rd_evt.
module bus_strobe (
  input  logic clk,
  input  logic rst,
  input  logic i_ce,
  input  logic i_rwb,
  output logic o_wr_evt,
  output logic o_rd_evt
);

  logic w_wr;
  logic w_rd;
  logic r_wr_q;
  logic r_rd_q;

  assign w_wr = i_ce & ~i_rwb;
  assign w_rd = i_ce & i_rwb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_q <= 1'b0;
      r_rd_q <= 1'b0;
    end else begin
      r_wr_q <= w_wr;
      r_rd_q <= w_rd;
    end
  end

  // Rising edge of each access level
  assign o_wr_evt = w_wr & ~r_wr_q;
  assign o_rd_evt = w_rd & ~r_rd_q;

endmodule

// File: rtl/mac_accum.sv
// mac_accum: adds/subtracts the multiplier product into a 24-bit accumulator on CPU command.
// Latency: command event at edge N -> acc updated, done pulse, busy low after edge N+1+SETTLE.
// Backpressure: GO while busy is dropped and flagged in sticky STATUS.lost.
// Ports: clk, rst, prod, D (6502 data, tristate), bus (CE/RWB/RS), busy, done, acc.
module mac_accum
  import mac_accum_pkg::*;
#(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PROD_W-1:0] prod,
  inout  wire  [7:0]        D,
  mac_accum_if.slave        bus,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  acc
);

  localparam logic [3:0] CNT_INIT = 4'((SETTLE > 0) ? SETTLE - 1 : 0);

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_cnt, w_cnt_nxt;
  logic             r_sub, w_sub_nxt;
  logic [ACC_W-1:0] r_acc, w_acc_nxt;
  logic [ACC_W-9:0] r_shadow, w_shadow_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             r_lost, w_lost_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;

  logic             w_wr_evt, w_rd_evt;
  logic             w_ctrl_wr, w_go, w_clr;
  logic [ACC_W-1:0] w_prod_ext;
  logic [ACC_W:0]   w_sum;
  logic [7:0]       w_status, w_rd_dat;
  logic             w_unused_d;

  bus_strobe u_strobe (
    .clk      (clk),
    .rst      (rst),
    .i_ce     (bus.CE),
    .i_rwb    (bus.RWB),
    .o_wr_evt (w_wr_evt),
    .o_rd_evt (w_rd_evt)
  );

  // CTRL decode; CLR wins over GO in the same write
  assign w_ctrl_wr  = w_wr_evt & (bus.RS == REG_CTRL);
  assign w_go       = w_ctrl_wr & D[CTRL_GO] & ~D[CTRL_CLR];
  assign w_clr      = w_ctrl_wr & D[CTRL_CLR];
  assign w_unused_d = ^D[7:3];

  // Extra top bit carries the add carry-out or the subtract borrow
  assign w_prod_ext = ACC_W'(prod);
  assign w_sum = r_sub ? ({1'b0, r_acc} - {1'b0, w_prod_ext})
                       : ({1'b0, r_acc} + {1'b0, w_prod_ext});

  assign w_status = {4'b0000, r_lost, (r_acc != '0), r_ovf, r_busy};

  always_comb begin
    w_rd_dat = w_status;
    case (bus.RS)
      REG_B0:  w_rd_dat = r_acc[7:0];
      REG_B1:  w_rd_dat = r_shadow[7:0];
      REG_B2:  w_rd_dat = r_shadow[15:8];
      default: w_rd_dat = w_status;
    endcase
  end

  assign D = (bus.CE & bus.RWB) ? w_rd_dat : 8'hzz;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_sub_nxt    = r_sub;
    w_acc_nxt    = r_acc;
    w_shadow_nxt = r_shadow;
    w_ovf_nxt    = r_ovf;
    w_lost_nxt   = r_lost;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;

    // Reading byte 0 freezes the upper bytes (pre-update value) for an atomic 24-bit read
    if (w_rd_evt && (bus.RS == REG_B0)) begin
      w_shadow_nxt = r_acc[ACC_W-1:8];
    end

    case (r_state)
      IDLE: begin
        if (w_go) begin
          w_sub_nxt  = D[CTRL_SUB];
          w_busy_nxt = 1'b1;
          w_cnt_nxt  = CNT_INIT;
          w_state_nxt = (SETTLE == 0) ? ACCUM : WAIT;
        end
      end
      WAIT: begin
        if (w_go) w_lost_nxt = 1'b1;
        if (r_cnt == 4'd0) begin
          w_state_nxt = ACCUM;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ACCUM: begin
        if (w_go) w_lost_nxt = 1'b1;
        w_acc_nxt   = w_sum[ACC_W-1:0];
        if (w_sum[ACC_W]) w_ovf_nxt = 1'b1;
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase

    // CLR aborts any command in flight; shadow is left untouched
    if (w_clr) begin
      w_acc_nxt   = '0;
      w_ovf_nxt   = 1'b0;
      w_lost_nxt  = 1'b0;
      w_state_nxt = IDLE;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_sub    <= 1'b0;
      r_acc    <= '0;
      r_shadow <= '0;
      r_ovf    <= 1'b0;
      r_lost   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_sub    <= w_sub_nxt;
      r_acc    <= w_acc_nxt;
      r_shadow <= w_shadow_nxt;
      r_ovf    <= w_ovf_nxt;
      r_lost   <= w_lost_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign acc  = r_acc;

endmodule

// File: tb/tb_mac_accum.sv
// tb_mac_accum: directed bench for mac_accum (SETTLE=1 main instance, SETTLE=4 companion).
// Latency: n/a.
// Backpressure: n/a.
module tb_mac_accum;
  import mac_accum_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] prod;
  logic [7:0]  tb_d;
  logic        tb_oe;
  wire  [7:0]  D;
  wire  [7:0]  D4;
  logic        busy, done, busy4, done4;
  logic [23:0] acc, acc4;
  int          total = 0;
  int          bad = 0;

  assign D  = tb_oe ? tb_d : 8'hzz;
  assign D4 = tb_oe ? tb_d : 8'hzz;

  mac_accum_if bus ();

  mac_accum #(.PROD_W(16), .ACC_W(24), .SETTLE(1)) u_dut (
    .clk(clk), .rst(rst), .prod(prod), .D(D), .bus(bus),
    .busy(busy), .done(done), .acc(acc)
  );

  mac_accum #(.PROD_W(16), .ACC_W(24), .SETTLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .prod(prod), .D(D4), .bus(bus),
    .busy(busy4), .done(done4), .acc(acc4)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.CE = 1'b0; bus.RWB = 1'b1; bus.RS = 2'd0; tb_oe = 1'b1; tb_d = 8'h00;
  endtask

  task automatic do_reset();
    idle_bus();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] rs, input logic [7:0] dat);
    bus.CE = 1'b1; bus.RWB = 1'b0; bus.RS = rs; tb_oe = 1'b1; tb_d = dat;
    cyc();
    idle_bus();
  endtask

  task automatic bus_read(input logic [1:0] rs, output logic [7:0] dat, output logic [7:0] dat4);
    bus.CE = 1'b1; bus.RWB = 1'b1; bus.RS = rs; tb_oe = 1'b0;
    #1;
    dat = D; dat4 = D4;
    cyc();
    idle_bus();
    cyc();
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 20) begin cyc(); n++; end
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL wait_done: done=%b required 1 within 20 cycles", done); end
  endtask

  task automatic test_reset();
    logic [7:0] r, r4;
    do_reset();
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || acc !== 24'h0) begin
      bad++; $display("FAIL reset_out: busy=%b done=%b acc=%h required 0 0 000000", busy, done, acc);
    end
    total++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || acc4 !== 24'h0) begin
      bad++; $display("FAIL reset_out4: busy=%b done=%b acc=%h required 0 0 000000", busy4, done4, acc4);
    end
    for (int i = 0; i < 4; i++) begin
      bus_read(2'(i), r, r4);
      total++;
      if (r !== 8'h00 || r4 !== 8'h00) begin
        bad++; $display("FAIL reset_reg%0d: got %h/%h required 00", i, r, r4);
      end
    end
  endtask

  task automatic test_single();
    logic [6:0] eb  = 7'b0000011;
    logic [6:0] ed  = 7'b0000100;
    logic [6:0] eb4 = 7'b0011111;
    logic [6:0] ed4 = 7'b0100000;
    logic [7:0] r, r4;
    do_reset();
    prod = 16'h1234;
    bus.CE = 1'b1; bus.RWB = 1'b0; bus.RS = REG_CTRL; tb_oe = 1'b1; tb_d = 8'h01;
    for (int i = 0; i < 7; i++) begin
      cyc();
      if (i == 4) idle_bus();
      total++;
      if (busy !== eb[i] || done !== ed[i]) begin
        bad++; $display("FAIL single_t%0d: busy=%b done=%b required %b %b", i, busy, done, eb[i], ed[i]);
      end
      total++;
      if (busy4 !== eb4[i] || done4 !== ed4[i]) begin
        bad++; $display("FAIL single4_t%0d: busy=%b done=%b required %b %b", i, busy4, done4, eb4[i], ed4[i]);
      end
    end
    total++;
    if (acc !== 24'h001234 || acc4 !== 24'h001234) begin
      bad++; $display("FAIL single_acc: got %h/%h required 001234", acc, acc4);
    end
    bus_read(REG_B0, r, r4);
    total++; if (r !== 8'h34) begin bad++; $display("FAIL single_b0: got %h required 34", r); end
    bus_read(REG_B1, r, r4);
    total++; if (r !== 8'h12) begin bad++; $display("FAIL single_b1: got %h required 12", r); end
    bus_read(REG_B2, r, r4);
    total++; if (r !== 8'h00) begin bad++; $display("FAIL single_b2: got %h required 00", r); end
    // Deselected: only the bench drives D
    bus.CE = 1'b0; bus.RWB = 1'b1; bus.RS = REG_B0; tb_oe = 1'b1; tb_d = 8'h00;
    #1;
    total++; if (D !== 8'h00) begin bad++; $display("FAIL release_d: got %h required 00", D); end
    idle_bus();
    cyc();
  endtask

  task automatic test_overflow();
    logic [7:0] r, r4;
    do_reset();
    prod = 16'hFFFF;
    for (int i = 0; i < 256; i++) begin
      bus_write(REG_CTRL, 8'h01);
      wait_done();
    end
    total++; if (acc !== 24'hFFFF00) begin bad++; $display("FAIL ovf_sum: got %h required ffff00", acc); end
    bus_read(REG_CTRL, r, r4);
    total++; if (r !== 8'h04) begin bad++; $display("FAIL ovf_status0: got %h required 04", r); end
    prod = 16'h0100;
    bus_write(REG_CTRL, 8'h01);
    wait_done();
    total++; if (acc !== 24'h000000) begin bad++; $display("FAIL ovf_wrap: got %h required 000000", acc); end
    bus_read(REG_CTRL, r, r4);
    total++; if (r !== 8'h02) begin bad++; $display("FAIL ovf_status1: got %h required 02", r); end
  endtask

  task automatic test_sub();
    logic [7:0] r, r4;
    do_reset();
    prod = 16'h0010;
    bus_write(REG_CTRL, 8'h01);
    wait_done();
    prod = 16'h0020;
    bus_write(REG_CTRL, 8'h03);
    wait_done();
    total++; if (acc !== 24'hFFFFF0) begin bad++; $display("FAIL sub_acc: got %h required fffff0", acc); end
    bus_read(REG_CTRL, r, r4);
    total++; if (r !== 8'h06) begin bad++; $display("FAIL sub_status: got %h required 06", r); end
    bus_read(REG_B0, r, r4);
    total++; if (r !== 8'hF0) begin bad++; $display("FAIL sub_b0: got %h required f0", r); end
    bus_read(REG_B2, r, r4);
    total++; if (r !== 8'hFF) begin bad++; $display("FAIL sub_b2: got %h required ff", r); end
  endtask

  task automatic test_lost_clr();
    logic [7:0] r, r4;
    logic seen;
    do_reset();
    prod = 16'h0005;
    bus_write(REG_CTRL, 8'h01);
    cyc();
    bus_write(REG_CTRL, 8'h01);
    wait_done();
    for (int i = 0; i < 8; i++) cyc();
    total++;
    if (acc !== 24'h000005 || acc4 !== 24'h000005) begin
      bad++; $display("FAIL lost_acc: got %h/%h required 000005", acc, acc4);
    end
    bus_read(REG_CTRL, r, r4);
    total++;
    if (r !== 8'h0C || r4 !== 8'h0C) begin bad++; $display("FAIL lost_status: got %h/%h required 0c", r, r4); end
    // GO, then CLR two cycles later: SETTLE=4 copy is mid-WAIT, SETTLE=1 copy is in ACCUM
    bus_write(REG_CTRL, 8'h01);
    cyc();
    bus_write(REG_CTRL, 8'h05);
    seen = done | done4;
    for (int i = 0; i < 8; i++) begin cyc(); seen = seen | done | done4; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL clr_done: pulse seen=%b required 0", seen); end
    total++;
    if (busy !== 1'b0 || busy4 !== 1'b0 || acc !== 24'h0 || acc4 !== 24'h0) begin
      bad++; $display("FAIL clr_state: busy=%b/%b acc=%h/%h required 0 000000", busy, busy4, acc, acc4);
    end
    bus_read(REG_CTRL, r, r4);
    total++;
    if (r !== 8'h00 || r4 !== 8'h00) begin bad++; $display("FAIL clr_status: got %h/%h required 00", r, r4); end
  endtask

  task automatic test_shadow();
    logic [7:0] r, r4;
    do_reset();
    prod = 16'h00FF;
    bus_write(REG_CTRL, 8'h01);
    wait_done();
    prod = 16'h0001;
    bus_read(REG_B0, r, r4);
    total++; if (r !== 8'hFF) begin bad++; $display("FAIL shd_b0: got %h required ff", r); end
    bus_write(REG_CTRL, 8'h01);
    wait_done();
    bus_read(REG_B1, r, r4);
    total++; if (r !== 8'h00) begin bad++; $display("FAIL shd_b1_old: got %h required 00", r); end
    bus_read(REG_B2, r, r4);
    total++; if (r !== 8'h00) begin bad++; $display("FAIL shd_b2_old: got %h required 00", r); end
    bus_read(REG_B0, r, r4);
    total++; if (r !== 8'h00) begin bad++; $display("FAIL shd_b0_new: got %h required 00", r); end
    bus_read(REG_B1, r, r4);
    total++; if (r !== 8'h01) begin bad++; $display("FAIL shd_b1_new: got %h required 01", r); end
    // Byte-0 read lands on the same edge as the ACCUM update: pre-update values win
    prod = 16'hFF00;
    bus_write(REG_CTRL, 8'h01);
    cyc();
    bus_read(REG_B0, r, r4);
    total++; if (r !== 8'h00) begin bad++; $display("FAIL race_b0: got %h required 00", r); end
    total++; if (acc !== 24'h010000) begin bad++; $display("FAIL race_acc: got %h required 010000", acc); end
    bus_read(REG_B1, r, r4);
    total++; if (r !== 8'h01) begin bad++; $display("FAIL race_b1: got %h required 01", r); end
    bus_read(REG_B2, r, r4);
    total++; if (r !== 8'h00) begin bad++; $display("FAIL race_b2: got %h required 00", r); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    rst  = 1'b1;
    prod = 16'h0000;
    idle_bus();
    test_reset();
    test_single();
    test_overflow();
    test_sub();
    test_lost_clr();
    test_shadow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_accum.md
Name: mac_accum

Overview:
- Downstream companion stage to the 8x8 multiplication accelerator on the 6502 bus.
- Consumes the multiplier's 16-bit combinational product, `prod`, and adds it to, or subtracts it from, a 24-bit accumulator on CPU command.
- Exposes control, status and accumulator bytes to the 6502 through its own chip-select and 2-bit register select.
- Supports multiply-accumulate loops without CPU-side 16/24-bit arithmetic.

Parameters:
- PROD_W, 16, width of the product input.
- ACC_W, 24, accumulator width; fixed at 3 bytes for the register map.
- SETTLE, 1, clk cycles to wait after command before sampling `prod`; range 0..15.

Ports:
- clk  in  1  single system clock, all state on posedge.
- rst  in  1  synchronous, active-high reset.
- prod  in  PROD_W  unsigned product from the multiplier stage.
- D  inout  8  6502 data bus.
- RWB  in  1  6502 read/write: 1 = CPU read, 0 = CPU write.
- CE  in  1  chip enable from the address decoder, active high.
- RS  in  2  register select (CPU address bits 1:0).
- busy  out  1  high while a command is in flight.
- done  out  1  one-cycle pulse when the accumulator has been updated.
- acc  out  ACC_W  accumulator value, for debug and IRQ logic.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: acc=0, shadow=0, ovf=0, lost=0, state=IDLE, busy=0, done=0, wr_q=0, rd_q=0. `rst` mid-command aborts the command; no acc update, no done pulse.
- Strobes:
  - wr_q<=CE&~RWB and rd_q<=CE&RWB each cycle.
  - Write event: (CE&~RWB)&~wr_q. Read event: (CE&RWB)&~rd_q.
  - A bus access held for many cycles therefore acts exactly once.
  - D and RS are sampled on the event cycle.
- Register map, write side:
  - RS=0 write is CTRL. bit0 GO, bit1 SUB, bit2 CLR; other bits ignored.
  - RS=1..3 writes are ignored.
- Register map, read side:
  - RS=0 read is STATUS = {4'b0, lost, nz, ovf, busy}; nz = (acc!=0).
  - RS=1 read returns acc[7:0]. Its read event copies acc[23:8] into shadow on the same edge.
  - RS=2 read returns shadow[7:0]; RS=3 read returns shadow[15:8]. The 24-bit read is atomic if the CPU reads byte 1 first.
- D drive: D = mux(RS) when CE&RWB, else 8'hZZ. Purely combinational, no latency.
- FSM states: IDLE, WAIT, ACCUM.
  - IDLE + write event with GO=1, CLR=0: latch SUB; state<=WAIT with cnt<=SETTLE-1, or ACCUM if SETTLE=0; busy<=1.
  - WAIT: decrement cnt; at cnt==0 go to ACCUM.
  - ACCUM: sample prod that cycle.
    - acc <= acc ± zero-extended prod, wrapping mod 2^24.
    - ovf<=1 on carry-out (add) or borrow (sub). ovf is sticky.
    - done<=1 for one cycle; state<=IDLE; busy<=0.
- Latency: a command event at edge N gives acc updated, done=1 and busy=0 after edge N+1+SETTLE. busy is 1 from edge N through N+SETTLE.
- GO while busy: command ignored; lost<=1 (sticky).
- CLR (any state, takes priority over GO in the same write):
  - acc<=0, ovf<=0, lost<=0, state<=IDLE, busy<=0, no done pulse.
  - Shadow is not cleared.
- Read event at RS=1 in the same cycle that ACCUM updates acc: shadow captures the pre-update acc[23:8]. Read data is the pre-update acc[7:0].
- Reading STATUS does not clear sticky bits.

Decomposition:
- Package mac_accum_pkg:
  - state_t enum {IDLE, WAIT, ACCUM}.
  - Register offsets REG_CTRL=0, REG_B0=1, REG_B1=2, REG_B2=3.
  - CTRL bit indices GO=0, SUB=1, CLR=2.
  - STATUS bit indices BUSY=0, OVF=1, NZ=2, LOST=3.
- One sub-module, bus_strobe: registers CE/RWB and produces the single-cycle wr_evt and rd_evt. Reusable by the multiplier stage.

Test Plan:
- Reset then read all four registers -> STATUS=0x00, bytes 0x00/0x00/0x00; D is Z whenever CE=0.
- prod=0x1234, write CTRL=0x01 held 5 cycles -> exactly one accumulate:
  - busy high for 2 cycles, done pulse at N+2.
  - Read byte0 = 0x34, byte1 = 0x12, byte2 = 0x00.
- Accumulate prod=0xFFFF 256 times -> acc=0xFFFF00, ovf=0. One more accumulate of 0x0100 -> acc=0x000000, ovf=1, STATUS=0x02.
- From acc=0x000010, write CTRL=0x03 with prod=0x0020 -> acc=0xFFFFF0, ovf=1, nz=1.
- Issue GO, then GO again while busy=1 -> one update only, STATUS.lost=1. Then CLR mid-WAIT -> acc=0, busy=0, no done pulse, STATUS=0x00.
- acc=0x0000FF, read RS=1, accumulate prod=0x0001, then read RS=2/3 -> byte0=0xFF and shadow bytes 0x00/0x00 (not 0x01). Re-reading RS=1 then RS=2 gives 0x00/0x01.
